// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the E stage of a MIPS-style pipeline.
// The full 64-bit result is computed on the start cycle and held in a pending
// register. A down-counter then models the unit's latency, and HI/LO are
// written on the last busy edge.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - asynchronous, active-low reset
//   start    - E-stage instruction is an MD op this cycle
//   op[2:0]  - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   a, b     - forwarded rs / rt operands
//   flush    - E-stage instruction cancelled this cycle
//   d_is_md  - D-stage instruction uses HI/LO or the MD unit
//   busy     - computation in progress (registered)
//   stall    - freeze D, bubble into E (combinational)
//   hi, lo   - architectural HI/LO registers
module md_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [63:0]   pend_r;
    logic          pend_wr_r;
    logic          busy_r;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;

    logic          accept_s;
    logic          div_zero_s;
    logic [63:0]   sprod_s;
    logic [63:0]   uprod_s;
    logic [31:0]   dvsr_s;
    logic [31:0]   abs_a_s;
    logic [31:0]   abs_b_s;
    logic [31:0]   sq_mag_s;
    logic [31:0]   sr_mag_s;
    logic [31:0]   squot_s;
    logic [31:0]   srem_s;
    logic [63:0]   res_s;

    assign accept_s   = start & ~flush & ~busy_r;
    assign div_zero_s = (b == 32'd0);

    // Result datapath: products plus sign-magnitude division. Working on
    // magnitudes makes 0x80000000 / -1 wrap to 0x80000000 with no special
    // case. A zero divisor is replaced by 1 only so the divide stays defined;
    // that result is never committed.
    always_comb begin
        sprod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod_s  = {32'd0, a} * {32'd0, b};
        dvsr_s   = div_zero_s ? 32'd1 : b;
        abs_a_s  = a[31] ? (~a + 32'd1) : a;
        abs_b_s  = b[31] ? (~dvsr_s + 32'd1) : dvsr_s;
        sq_mag_s = abs_a_s / abs_b_s;
        sr_mag_s = abs_a_s % abs_b_s;
        squot_s  = (a[31] ^ b[31]) ? (~sq_mag_s + 32'd1) : sq_mag_s;
        srem_s   = a[31] ? (~sr_mag_s + 32'd1) : sr_mag_s;
        case (op)
            3'd0:    res_s = sprod_s;
            3'd1:    res_s = uprod_s;
            3'd2:    res_s = {srem_s, squot_s};
            3'd3:    res_s = {a % dvsr_s, a / dvsr_s};
            default: res_s = 64'd0;
        endcase
    end

    // Scheduler FSM: latch the result on an accepted start, count the
    // latency down, then commit HI/LO. Direct moves write HI/LO immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            pend_r    <= 64'd0;
            pend_wr_r <= 1'b0;
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        case (op)
                            3'd0, 3'd1: begin
                                pend_r    <= res_s;
                                pend_wr_r <= 1'b1;
                                cnt_r     <= CW'(MULT_CYC);
                                state_r   <= RUN;
                                busy_r    <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                pend_r    <= res_s;
                                pend_wr_r <= ~div_zero_s;
                                cnt_r     <= CW'(DIV_CYC);
                                state_r   <= RUN;
                                busy_r    <= 1'b1;
                            end
                            3'd4:    hi_r <= a;
                            3'd5:    lo_r <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // start and flush are ignored here: the committed op finishes
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        if (pend_wr_r) begin
                            hi_r <= pend_r[63:32];
                            lo_r <= pend_r[31:0];
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // stall is gated by reset because start is a live input during reset.
    assign stall = reset & d_is_md & (busy_r | (start & ~flush & (op <= 3'd3)));
    assign busy  = busy_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: a table of single-op vectors with
// hand-computed results, plus directed sequences for direct moves, flush,
// start-while-busy and reset in the middle of a divide.
module tb_md_sched;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .d_is_md(d_is_md), .busy(busy), .stall(stall),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One op with d_is_md held high: check stall on the start cycle and on
    // every busy cycle, the busy length, then HI/LO once busy drops.
    task automatic run_vec(input vec_t v);
        int cnt;
        int sc;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b; flush = 1'b0; d_is_md = 1'b1;
        #1 check({v.name, " stall@start"}, 64'(stall), 64'(v.op <= 3'd3));
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        sc  = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (stall) sc++;
            @(negedge clk);
        end
        check({v.name, " busy_cycles"}, 64'(cnt), 64'(v.cyc));
        check({v.name, " stall_cycles"}, 64'(sc), 64'(v.cyc));
        check({v.name, " hi"}, 64'(hi), 64'(v.hi));
        check({v.name, " lo"}, 64'(lo), 64'(v.lo));
        check({v.name, " stall_after"}, 64'(stall), 64'd0);
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{"mult_neg",   3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{"multu_max",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{"mult_pos",   3'd0, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 5};
        vecs[3]  = '{"divu_100_7", 3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[4]  = '{"divu_big",   3'd3, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 10};
        vecs[5]  = '{"div_neg_a",  3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[6]  = '{"div_neg_b",  3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7]  = '{"div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[8]  = '{"div_by_0",   3'd2, 32'd5,        32'd0,        32'h00000000, 32'h80000000, 10};
        vecs[9]  = '{"mthi",       3'd4, 32'hCAFEF00D, 32'd0,        32'hCAFEF00D, 32'h80000000, 0};
        vecs[10] = '{"mtlo",       3'd5, 32'h0BADBEEF, 32'd0,        32'hCAFEF00D, 32'h0BADBEEF, 0};
        vecs[11] = '{"op7_noop",   3'd7, 32'h11111111, 32'h2,        32'hCAFEF00D, 32'h0BADBEEF, 0};

        // Reset held with a live start: nothing may move, stall stays low.
        reset = 1'b0; start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        flush = 1'b0; d_is_md = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        start = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // mthi then mtlo on back-to-back cycles.
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h12345678;
        @(negedge clk);
        check("mthi hi", 64'(hi), 64'h12345678);
        check("mthi lo", 64'(lo), 64'h0BADBEEF);
        check("mthi busy", 64'(busy), 64'd0);
        op = 3'd5; a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo hi", 64'(hi), 64'h12345678);
        check("mtlo lo", 64'(lo), 64'h9ABCDEF0);
        check("mtlo busy", 64'(busy), 64'd0);

        // Flushed start has no effect.
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd7; flush = 1'b1; d_is_md = 1'b1;
        #1 check("flush stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush hi", 64'(hi), 64'h12345678);
        check("flush lo", 64'(lo), 64'h9ABCDEF0);

        // mult 2*3, second start on RUN cycle 2 ignored, flush in RUN ignored.
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        if (busy) cnt++;
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
        if (busy) cnt++;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        if (busy) cnt++;
        @(negedge clk);
        flush = 1'b0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("ignore busy_cycles", 64'(cnt), 64'd5);
        check("ignore hi", 64'(hi), 64'd0);
        check("ignore lo", 64'(lo), 64'd6);
        check("ignore busy_after", 64'(busy), 64'd0);

        // Reset in the middle of a divide discards the pending result.
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst stall", 64'(stall), 64'd0);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("postrst hi", 64'(hi), 64'd0);
        check("postrst lo", 64'(lo), 64'd0);
        run_vec('{"postrst_mult", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 5});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
